divider_ctrl: RTL and testbench

- Run/stop sequencer and configuration controller for a half-period clock divider datapath.
- Owns the half-period counter and the divided output.
- Accepts new half-period values over a valid/ready handshake and applies them only at a half-period boundary, so the output never glitches.
- Guarantees a clean stop with clk_div low. Sits between the top-level control logic and any slow-clock consumers (display scan, debounce, blink).

---
 rtl/divider_ctrl_pkg.sv | 11 +
 rtl/divider_ctrl_if.sv | 24 ++
 rtl/divider_ctrl_half_period_counter.sv | 35 +++
 rtl/divider_ctrl.sv | 147 ++++++++++++++
 tb/tb_divider_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/divider_ctrl_pkg.sv
// Shared constants for the clock-divider controller: FSM state encoding and
// the width of the optional period counter (DIVCTRL_PERIOD_CNT_EN).
package divctrl_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RUN      = 2'd1;
  localparam logic [1:0] ST_STOPPING = 2'd2;

  localparam int PERIOD_CNT_W = 16;

endpackage

// File: rtl/divider_ctrl_if.sv
// Run/config/output bundle between the top-level control logic (master)
// and the divider controller (slave).
interface divider_ctrl_if #(
  parameter int CNT_W = 14
);
  logic             run_req;
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_half;
  logic             cfg_ready;
  logic             cfg_err;
  logic             clk_div;
  logic             tick;
  logic             running;

  modport master (
    output run_req, cfg_valid, cfg_half,
    input  cfg_ready, cfg_err, clk_div, tick, running
  );

  modport slave (
    input  run_req, cfg_valid, cfg_half,
    output cfg_ready, cfg_err, clk_div, tick, running
  );
endinterface

// File: rtl/divider_ctrl_half_period_counter.sv
// Half-period counter: counts 0..half-1 while enabled and flags the last
// count of each half-period as the boundary.
module half_period_counter #(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] half,
  output logic [CNT_W-1:0] count,
  output logic             boundary
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_last;

  // half is never 0, so half-1 cannot wrap
  assign w_last   = half - ONE;
  assign boundary = en & (r_count == w_last);
  assign count    = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= boundary ? '0 : r_count + ONE;
    end
  end

endmodule

// File: rtl/divider_ctrl.sv
// Run/stop sequencer and glitch-free reconfiguration for a half-period clock
// divider. Define DIVCTRL_PERIOD_CNT_EN to add the period_cnt output.
module divider_ctrl
  import divctrl_pkg::*;
#(
  parameter int CNT_W        = 14,
  parameter int DEFAULT_HALF = 10000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  divider_ctrl_if.slave           bus
`ifdef DIVCTRL_PERIOD_CNT_EN
  ,
  output logic [PERIOD_CNT_W-1:0] period_cnt
`endif
);

  localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic             r_clk_div;
  logic             r_tick;
  logic             r_cfg_err;
  logic             r_cfg_ready;
  logic             r_running;
  logic [CNT_W-1:0] r_active_half;
  logic [CNT_W-1:0] w_active_half_next;
  logic [CNT_W-1:0] r_pending;
  logic [CNT_W-1:0] w_pending_next;
  logic             r_pending_valid;
  logic             w_pending_valid_next;

  logic             w_accept;
  logic             w_cfg_zero;
  logic             w_cfg_take;
  logic             w_en;
  logic             w_clr;
  logic             w_to_idle;
  logic [CNT_W-1:0] w_count;
  logic             w_boundary;

  assign w_accept   = bus.cfg_valid & r_cfg_ready;
  assign w_cfg_zero = (bus.cfg_half == '0);
  assign w_cfg_take = w_accept & ~w_cfg_zero;

  // A low phase is never finished in STOPPING, so the counter only runs there while high
  assign w_en  = (r_state == ST_RUN) | ((r_state == ST_STOPPING) & r_clk_div);
  assign w_clr = (w_state_next == ST_IDLE);

  half_period_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (w_en),
    .clr      (w_clr),
    .half     (r_active_half),
    .count    (w_count),
    .boundary (w_boundary)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:     if (bus.run_req) w_state_next = ST_RUN;
      ST_RUN:      if (!bus.run_req) w_state_next = ST_STOPPING;
      ST_STOPPING: if (!r_clk_div || w_boundary) w_state_next = ST_IDLE;
      default:     w_state_next = ST_IDLE;
    endcase
  end

  assign w_to_idle = (r_state != ST_IDLE) & (w_state_next == ST_IDLE);

  // An accept needs cfg_ready, i.e. no pending value, so apply and accept never collide
  always_comb begin
    w_active_half_next   = r_active_half;
    w_pending_next       = r_pending;
    w_pending_valid_next = r_pending_valid;
    if ((w_boundary | w_to_idle) & r_pending_valid) begin
      w_active_half_next   = r_pending;
      w_pending_valid_next = 1'b0;
    end
    if (w_cfg_take) begin
      if ((r_state == ST_IDLE) | w_to_idle) begin
        w_active_half_next = bus.cfg_half;
      end else begin
        w_pending_next       = bus.cfg_half;
        w_pending_valid_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_clk_div       <= 1'b0;
      r_tick          <= 1'b0;
      r_cfg_err       <= 1'b0;
      r_cfg_ready     <= 1'b1;
      r_running       <= 1'b0;
      r_active_half   <= RST_HALF;
      r_pending       <= '0;
      r_pending_valid <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_tick          <= w_boundary;
      r_cfg_err       <= w_accept & w_cfg_zero;
      r_cfg_ready     <= ~w_pending_valid_next;
      r_running       <= (w_state_next != ST_IDLE);
      r_active_half   <= w_active_half_next;
      r_pending       <= w_pending_next;
      r_pending_valid <= w_pending_valid_next;
      if (w_boundary) begin
        r_clk_div <= ~r_clk_div;
      end
    end
  end

`ifdef DIVCTRL_PERIOD_CNT_EN
  logic [PERIOD_CNT_W-1:0] r_period_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period_cnt <= '0;
    end else if ((r_state == ST_IDLE) && (w_state_next == ST_RUN)) begin
      r_period_cnt <= '0;
    end else if (w_boundary && r_clk_div) begin
      r_period_cnt <= r_period_cnt + PERIOD_CNT_W'(1);
    end
  end

  assign period_cnt = r_period_cnt;
`endif

  assign bus.clk_div   = r_clk_div;
  assign bus.tick      = r_tick;
  assign bus.cfg_err   = r_cfg_err;
  assign bus.cfg_ready = r_cfg_ready;
  assign bus.running   = r_running;

  // The counter may never run past the last count of the active half-period
  a_count_in_range : assert property (@(posedge clk) disable iff (!rst_n)
    w_count <= r_active_half - ONE);

endmodule

// File: tb/tb_divider_ctrl.sv
// Directed bench for divider_ctrl with DEFAULT_HALF=4: cycle-by-cycle vector
// table plus hand sequences for reset-in-run, truncated stop and period_cnt.
module tb_divider_ctrl;
  import divctrl_pkg::*;

  localparam int CNT_W = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  divider_ctrl_if #(.CNT_W(CNT_W)) bus ();

`ifdef DIVCTRL_PERIOD_CNT_EN
  logic [PERIOD_CNT_W-1:0] period_cnt;
`endif

  divider_ctrl #(
    .CNT_W        (CNT_W),
    .DEFAULT_HALF (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave)
`ifdef DIVCTRL_PERIOD_CNT_EN
    ,
    .period_cnt (period_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic             r;
    logic             v;
    logic [CNT_W-1:0] h;
    logic             clk_div;
    logic             tick;
    logic             running;
    logic             ready;
    logic             err;
  } vec_t;

  vec_t vecs[36];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [CNT_W-1:0] h);
    bus.run_req   = r;
    bus.cfg_valid = v;
    bus.cfg_half  = h;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic cd, input logic tk,
                         input logic rn, input logic rd, input logic er);
    chk({tag, ".clk_div"}, bus.clk_div, cd);
    chk({tag, ".tick"}, bus.tick, tk);
    chk({tag, ".running"}, bus.running, rn);
    chk({tag, ".cfg_ready"}, bus.cfg_ready, rd);
    chk({tag, ".cfg_err"}, bus.cfg_err, er);
  endtask

  initial begin
    // r, v, half | clk_div, tick, running, cfg_ready, cfg_err (after the edge)
    vecs = '{
      '{1'b1, 1'b0, 14'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0},  // 1  enter RUN
      '{1'b1, 1'b0, 14'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b0, 14'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b0, 14'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b0, 14'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0},  // 5  first rise
      '{1'b1, 1'b0, 14'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b1, 14'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0},  // 7  cfg 2 mid-phase
      '{1'b1, 1'b0, 14'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b0, 14'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0},  // 9  boundary, half->2
      '{1'b1, 1'b0, 14'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b0, 14'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0},  // 11 2-cycle half
      '{1'b1, 1'b0, 14'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b1, 14'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},  // 13 cfg 3 on boundary
      '{1'b1, 1'b0, 14'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b0, 14'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0},  // 15 still half 2
      '{1'b1, 1'b0, 14'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b0, 14'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b0, 14'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0},  // 18 3-cycle half
      '{1'b1, 1'b1, 14'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1},  // 19 cfg 0 rejected
      '{1'b1, 1'b0, 14'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b0, 14'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0},  // 21 half still 3
      '{1'b0, 1'b0, 14'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0},  // 22 stop in high phase
      '{1'b1, 1'b0, 14'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0},  // 23 reassert ignored
      '{1'b1, 1'b0, 14'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0},  // 24 fall, IDLE
      '{1'b1, 1'b0, 14'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0},  // 25 restart
      '{1'b1, 1'b0, 14'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0},
      '{1'b0, 1'b0, 14'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0},  // 27 stop in low phase
      '{1'b0, 1'b0, 14'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},  // 28 IDLE, no toggle
      '{1'b0, 1'b0, 14'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
      '{1'b0, 1'b1, 14'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0},  // 30 cfg 1 in IDLE
      '{1'b1, 1'b0, 14'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b0, 14'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0},  // 32 clk/2
      '{1'b1, 1'b0, 14'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b0, 14'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0},
      '{1'b0, 1'b0, 14'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0},  // 35 stop on a fall
      '{1'b0, 1'b0, 14'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}   // 36 IDLE
    };

    bus.run_req   = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_half  = '0;

    // Reset values and 20 idle cycles
    #12;
    chk_all("in_reset", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b0, '0);
      chk_all($sformatf("idle%0d", i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    $display("idle: 20 cycles with run_req=0 checked");

    // Main cycle-accurate trace
    for (int i = 0; i < 36; i++) begin
      cyc(vecs[i].r, vecs[i].v, vecs[i].h);
      chk_all($sformatf("vec%0d", i + 1), vecs[i].clk_div, vecs[i].tick,
              vecs[i].running, vecs[i].ready, vecs[i].err);
      $display("vec %0d: run=%0b valid=%0b half=%0d -> clk_div=%0b tick=%0b running=%0b ready=%0b err=%0b",
               i + 1, vecs[i].r, vecs[i].v, vecs[i].h, bus.clk_div, bus.tick,
               bus.running, bus.cfg_ready, bus.cfg_err);
    end

    // Reset mid-run with a pending cfg: outputs clear, half returns to 4
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 14'd3);
    chk("pend_before_rst.cfg_ready", bus.cfg_ready, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_all("mid_run_rst", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1 rst_n = 1'b1;
    cyc(1'b1, 1'b0, '0);
    chk("rst_run.running", bus.running, 1'b1);
    for (int k = 2; k <= 4; k++) begin
      cyc(1'b1, 1'b0, '0);
      chk($sformatf("rst_half_low%0d", k), bus.clk_div, 1'b0);
    end
    cyc(1'b1, 1'b0, '0);
    chk("rst_half_rise.clk_div", bus.clk_div, 1'b1);
    chk("rst_half_rise.tick", bus.tick, 1'b1);
    $display("reset-in-run: pending discarded, half-period back to 4");

    // Pending cfg carried into IDLE by a low-phase stop
    for (int k = 6; k <= 8; k++) cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    chk("trunc_fall.clk_div", bus.clk_div, 1'b0);
    cyc(1'b1, 1'b1, 14'd2);
    chk("trunc_pend.cfg_ready", bus.cfg_ready, 1'b0);
    cyc(1'b0, 1'b0, '0);
    chk("trunc_stopping.running", bus.running, 1'b1);
    cyc(1'b0, 1'b0, '0);
    chk_all("trunc_idle", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, '0);
    chk("trunc_restart.running", bus.running, 1'b1);
    cyc(1'b1, 1'b0, '0);
    chk("trunc_half2_low", bus.clk_div, 1'b0);
    cyc(1'b1, 1'b0, '0);
    chk("trunc_half2_rise", bus.clk_div, 1'b1);
    $display("truncated stop: pending half 2 applied on entry to IDLE");

`ifdef DIVCTRL_PERIOD_CNT_EN
    // Three full periods at half 4 -> period_cnt = 3
    cyc(1'b0, 1'b0, '0);
    #2 rst_n = 1'b0;
    #1;
    chk("pcnt_reset", period_cnt, 0);
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      cyc(1'b1, 1'b0, '0);
      if (k == 8)  chk("pcnt_before_fall1", period_cnt, 0);
      if (k == 9)  chk("pcnt_fall1", period_cnt, 1);
      if (k == 24) chk("pcnt_before_fall3", period_cnt, 2);
      if (k == 25) chk("pcnt_fall3", period_cnt, 3);
    end
    $display("period_cnt: 3 periods counted");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 want 1");
    $fatal(1, "timeout");
  end

endmodule
